// File: rtl/vga_fetch_ctrl_if.sv
// Memory-bus port bundle for the video fetch sequencer.
// The fetcher is the bus master: it raises addr_strobe with a word address and
// holds both until the memory side answers with data_ready and data_in.
interface vga_fetch_ctrl_if #(
    parameter int addr_bits = 30
);
    logic                 addr_strobe;
    logic [addr_bits-1:0] addr;
    logic                 data_ready;
    logic [31:0]          data_in;

    modport master (
        output addr_strobe,
        output addr,
        input  data_ready,
        input  data_in
    );

    modport slave (
        input  addr_strobe,
        input  addr,
        output data_ready,
        output data_in
    );
endinterface

// File: rtl/vga_fetch_ctrl.sv
// Frame-buffer fetch sequencer: reads one frame of 32-bit words from memory,
// starting at base_addr, into a small show-ahead FIFO that feeds the planar
// video output. Every vsync restarts the frame; popping an empty FIFO latches
// a sticky underrun flag until the next restart.
module vga_fetch_ctrl #(
    parameter int addr_bits      = 30,
    parameter int fifo_log2      = 4,
    parameter int frame_words    = 38400,
    parameter int vsync_sync_len = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [addr_bits-1:0] base_addr,
    input  logic                 vga_vsync,
    input  logic                 rd,
    output logic [7:0]           red_byte,
    output logic [7:0]           green_byte,
    output logic [7:0]           blue_byte,
    output logic [7:0]           bright_byte,
    output logic [fifo_log2:0]   fifo_fill,
    output logic                 underrun,
    vga_fetch_ctrl_if.master     bus
);

    localparam int depth    = 1 << fifo_log2;
    localparam int cnt_bits = $clog2(frame_words + 1);

    localparam logic [fifo_log2:0] full_fill   = (fifo_log2 + 1)'(depth);
    localparam logic [cnt_bits-1:0] frame_count = cnt_bits'(frame_words);
    localparam logic [cnt_bits-1:0] last_count  = cnt_bits'(frame_words - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD,
        DONE
    } state_t;

    state_t                state_reg;
    logic                  strobe_reg;
    logic [addr_bits-1:0]  addr_reg;        // address presented on the bus
    logic [addr_bits-1:0]  fetch_addr_reg;  // next word to request
    logic [cnt_bits-1:0]   count_reg;

    logic                  vsync_sync_reg [vsync_sync_len];
    logic                  vsync_prev_reg;
    logic                  restart;

    logic [31:0]           fifo_mem [depth];
    logic [fifo_log2-1:0]  wr_ptr_reg;
    logic [fifo_log2-1:0]  rd_ptr_reg;
    logic [fifo_log2:0]    fill_reg;
    logic                  underrun_reg;
    logic                  push;
    logic                  pop;
    logic [31:0]           head;

    // ------------------------------------------------------------------
    // vsync synchronizer chain; flops idle high so reset does not look like
    // a falling edge.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < vsync_sync_len; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous pixel-domain vsync.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) vsync_sync_reg[gi] <= 1'b1;
                    else          vsync_sync_reg[gi] <= vga_vsync;
                end
            end else begin : g_rest
                // Later stages settle metastability.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) vsync_sync_reg[gi] <= 1'b1;
                    else          vsync_sync_reg[gi] <= vsync_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Delayed copy of the synchronized vsync for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vsync_prev_reg <= 1'b1;
        else          vsync_prev_reg <= vsync_sync_reg[vsync_sync_len-1];
    end

    assign restart = vsync_prev_reg & ~vsync_sync_reg[vsync_sync_len-1];

    // ------------------------------------------------------------------
    // Bus sequencer. Restart overrides everything; an in-flight request is
    // finished in DISCARD so the bus handshake stays intact.
    // ------------------------------------------------------------------
    // Single FSM with registered bus outputs, address and word count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            strobe_reg     <= 1'b0;
            addr_reg       <= '0;
            fetch_addr_reg <= '0;
            count_reg      <= '0;
        end else if (restart) begin
            fetch_addr_reg <= base_addr;
            count_reg      <= '0;
            if (strobe_reg && !bus.data_ready) begin
                state_reg <= DISCARD;
            end else begin
                // A word answered in this very cycle is simply not pushed.
                strobe_reg <= 1'b0;
                state_reg  <= enable ? FETCH : IDLE;
            end
        end else begin
            unique case (state_reg)
                IDLE: begin
                    strobe_reg <= 1'b0;
                end
                FETCH: begin
                    if (strobe_reg) begin
                        if (bus.data_ready) begin
                            strobe_reg     <= 1'b0;
                            fetch_addr_reg <= fetch_addr_reg + 1'b1;
                            count_reg      <= count_reg + 1'b1;
                            if (count_reg == last_count) state_reg <= DONE;
                            else if (!enable)            state_reg <= IDLE;
                        end
                    end else if (!enable) begin
                        state_reg <= IDLE;
                    end else if (fill_reg < full_fill && count_reg < frame_count) begin
                        // Registered fill: the one outstanding word always has room.
                        strobe_reg <= 1'b1;
                        addr_reg   <= fetch_addr_reg;
                    end
                end
                DISCARD: begin
                    if (bus.data_ready) begin
                        strobe_reg <= 1'b0;
                        state_reg  <= enable ? FETCH : IDLE;
                    end
                end
                DONE: begin
                    strobe_reg <= 1'b0;
                end
                default: begin
                    strobe_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr_strobe = strobe_reg;
    assign bus.addr        = addr_reg;

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    assign push = (state_reg == FETCH) && strobe_reg && bus.data_ready && !restart;
    assign pop  = rd && (fill_reg != '0) && !restart;

    // Storage write; no reset needed, contents are qualified by fill_reg.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= bus.data_in;
    end

    // Pointer and occupancy tracking; restart flushes to empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else if (restart) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      fill_reg <= fill_reg + 1'b1;
            else if (pop && !push) fill_reg <= fill_reg - 1'b1;
        end
    end

    // Sticky underrun: a display pop found nothing to show.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  underrun_reg <= 1'b0;
        else if (restart)              underrun_reg <= 1'b0;
        else if (rd && fill_reg == '0) underrun_reg <= 1'b1;
    end

    assign head        = fifo_mem[rd_ptr_reg];
    assign red_byte    = (fill_reg != '0) ? head[7:0]   : 8'h00;
    assign green_byte  = (fill_reg != '0) ? head[15:8]  : 8'h00;
    assign blue_byte   = (fill_reg != '0) ? head[23:16] : 8'h00;
    assign bright_byte = (fill_reg != '0) ? head[31:24] : 8'h00;
    assign fifo_fill   = fill_reg;
    assign underrun    = underrun_reg;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Bench for vga_fetch_ctrl: a memory responder answers bus requests with a
// known address-derived pattern and queues each delivered word; display pops
// compare the FIFO head against that queue.
`timescale 1ns/1ps
module tb_vga_fetch_ctrl;

    localparam int AB = 30;
    localparam int FL = 4;
    localparam int FW = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic          vga_vsync = 1'b1;
    logic          rd = 1'b0;
    logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;
    logic [FL:0]   fifo_fill;
    logic          underrun;

    vga_fetch_ctrl_if #(.addr_bits(AB)) bus ();

    vga_fetch_ctrl #(
        .addr_bits(AB), .fifo_log2(FL), .frame_words(FW), .vsync_sync_len(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .base_addr(base_addr),
        .vga_vsync(vga_vsync), .rd(rd),
        .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
        .bright_byte(bright_byte), .fifo_fill(fifo_fill), .underrun(underrun),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboard and memory responder state
    logic [31:0]   exp_q[$];
    logic          pend = 1'b0;      // last queued word driven but not yet clocked in
    logic [AB-1:0] exp_addr = '0;
    logic          busy = 1'b0;
    int            bus_wait = 0;
    int            bus_delay = 0;
    logic          bus_drop = 1'b0;
    int            req_cnt = 0;

    function automatic logic [31:0] word_of(input logic [AB-1:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = a[7:0];
        hi = a[15:8];
        return {lo + 8'h11, ~lo, hi ^ 8'h3C, lo};
    endfunction

    function automatic logic [31:0] model_pop();
        if (exp_q.size() > int'(pend)) return exp_q.pop_front();
        return 32'h0;
    endfunction

    // One clock: step past the edge, then act as the memory.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.data_ready) begin
            bus.data_ready = 1'b0;
            pend = 1'b0;
        end else if (bus.addr_strobe) begin
            if (!busy) begin
                busy = 1'b1;
                bus_wait = bus_delay;
                req_cnt++;
                tests_run++;
                if (bus.addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL req_addr: got 0x%0h expected 0x%0h", bus.addr, exp_addr);
                end
            end
            if (bus_wait == 0) begin
                bus.data_ready = 1'b1;
                bus.data_in = word_of(bus.addr);
                busy = 1'b0;
                if (bus_drop) begin
                    bus_drop = 1'b0;
                end else begin
                    exp_q.push_back(word_of(bus.addr));
                    exp_addr++;
                    pend = 1'b1;
                end
            end else begin
                bus_wait--;
            end
        end
    endtask

    task automatic do_rd(output logic [31:0] seen);
        seen = {bright_byte, blue_byte, green_byte, red_byte};
        rd = 1'b1;
        tick();
        rd = 1'b0;
        $display("[TB] rd pop head=0x%08h fill_after=%0d", seen, fifo_fill);
    endtask

    // vsync low pulse; restart lands on the third edge after the drop.
    task automatic pulse_vsync();
        vga_vsync = 1'b0;
        tick(); tick(); tick();
        exp_q.delete();
        pend = 1'b0;
        exp_addr = base_addr;
        req_cnt = 0;
        bus_drop = busy;
        vga_vsync = 1'b1;
        $display("[TB] vsync restart base=0x%0h", base_addr);
    endtask

    task automatic test_reset();
        bus.data_ready = 1'b0;
        bus.data_in = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.addr_strobe !== 1'b0) begin tests_failed++; $display("FAIL reset_strobe: got %b expected 0", bus.addr_strobe); end
        tests_run++;
        if (bus.addr !== '0) begin tests_failed++; $display("FAIL reset_addr: got 0x%0h expected 0", bus.addr); end
        tests_run++;
        if (fifo_fill !== 5'd0) begin tests_failed++; $display("FAIL reset_fill: got %0d expected 0", fifo_fill); end
        tests_run++;
        if ({bright_byte, blue_byte, green_byte, red_byte} !== 32'h0) begin
            tests_failed++; $display("FAIL reset_bytes: got 0x%08h expected 0", {bright_byte, blue_byte, green_byte, red_byte});
        end
        tests_run++;
        if (underrun !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        int n;
        int strobes;
        base_addr = 30'h1000;
        enable = 1'b1;
        bus_delay = 0;
        pulse_vsync();
        n = 0;
        while (fifo_fill !== 5'd16 && n < 200) begin tick(); n++; end
        tests_run++;
        if (fifo_fill !== 5'd16) begin tests_failed++; $display("FAIL fill_full: got %0d expected 16", fifo_fill); end
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.addr_strobe) strobes++;
        end
        tests_run++;
        if (strobes != 0) begin tests_failed++; $display("FAIL full_no_strobe: got %0d strobe cycles expected 0", strobes); end
        tests_run++;
        if (req_cnt != 16) begin tests_failed++; $display("FAIL fill_req_count: got %0d expected 16", req_cnt); end
        tests_run++;
        if ({bright_byte, blue_byte, green_byte, red_byte} !== word_of(30'h1000)) begin
            tests_failed++; $display("FAIL fill_head: got 0x%08h expected 0x%08h",
                                     {bright_byte, blue_byte, green_byte, red_byte}, word_of(30'h1000));
        end
    endtask

    task automatic test_steady_rd();
        logic [31:0] seen;
        logic [31:0] exp_w;
        int          minf;
        int          req0;
        for (int k = 0; k < 4; k++) begin
            req0 = req_cnt;
            exp_w = model_pop();
            do_rd(seen);
            tests_run++;
            if (seen !== exp_w) begin tests_failed++; $display("FAIL steady_head%0d: got 0x%08h expected 0x%08h", k, seen, exp_w); end
            minf = int'(fifo_fill);
            for (int i = 0; i < 7; i++) begin
                tick();
                if (int'(fifo_fill) < minf) minf = int'(fifo_fill);
            end
            tests_run++;
            if (minf != 15 || fifo_fill !== 5'd16) begin
                tests_failed++; $display("FAIL steady_fill%0d: got min %0d end %0d expected 15/16", k, minf, fifo_fill);
            end
            tests_run++;
            if (req_cnt - req0 != 1) begin tests_failed++; $display("FAIL steady_fetches%0d: got %0d expected 1", k, req_cnt - req0); end
        end
        tests_run++;
        if (underrun !== 1'b0) begin tests_failed++; $display("FAIL steady_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_frame_done();
        logic [31:0] seen;
        logic [31:0] exp_w;
        int          strobes;
        int          n;
        tests_run++;
        if (bus.addr !== 30'h1013) begin tests_failed++; $display("FAIL done_last_addr: got 0x%0h expected 0x1013", bus.addr); end
        tests_run++;
        if (req_cnt != FW) begin tests_failed++; $display("FAIL done_req_count: got %0d expected %0d", req_cnt, FW); end
        strobes = 0;
        for (int i = 0; i < 16; i++) begin
            exp_w = model_pop();
            do_rd(seen);
            if (bus.addr_strobe) strobes++;
            tests_run++;
            if (seen !== exp_w) begin tests_failed++; $display("FAIL done_head%0d: got 0x%08h expected 0x%08h", i, seen, exp_w); end
            tick();
            if (bus.addr_strobe) strobes++;
        end
        tests_run++;
        if (strobes != 0 || fifo_fill !== 5'd0) begin
            tests_failed++; $display("FAIL done_idle: got strobes %0d fill %0d expected 0/0", strobes, fifo_fill);
        end
        base_addr = 30'h2000;
        pulse_vsync();
        n = 0;
        while (req_cnt < 1 && n < 20) begin tick(); n++; end
        tests_run++;
        if (bus.addr !== 30'h2000) begin tests_failed++; $display("FAIL done_restart_addr: got 0x%0h expected 0x2000", bus.addr); end
    endtask

    task automatic test_discard();
        int n;
        int bad;
        n = 0;
        while (fifo_fill < 5'd4 && n < 50) begin tick(); n++; end
        bus_delay = 5;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        tests_run++;
        if (!busy) begin tests_failed++; $display("FAIL discard_setup: got no outstanding request expected one"); end
        base_addr = 30'h3000;
        pulse_vsync();
        bus_delay = 0;
        tests_run++;
        if (fifo_fill !== 5'd0) begin tests_failed++; $display("FAIL discard_flush: got %0d expected 0", fifo_fill); end
        bad = 0;
        n = 0;
        while (req_cnt < 1 && n < 30) begin
            tick();
            if (fifo_fill !== 5'd0) bad++;
            n++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL discard_fill: got %0d nonzero-fill cycles expected 0", bad); end
        tests_run++;
        if (bus.addr !== 30'h3000) begin tests_failed++; $display("FAIL discard_next_addr: got 0x%0h expected 0x3000", bus.addr); end
    endtask

    task automatic test_underrun();
        logic [31:0] seen;
        logic [31:0] exp_w;
        int          n;
        int          strobes;
        enable = 1'b0;
        repeat (6) tick();
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            exp_w = model_pop();
            do_rd(seen);
            tests_run++;
            if (seen !== exp_w) begin tests_failed++; $display("FAIL drain_head%0d: got 0x%08h expected 0x%08h", n, seen, exp_w); end
            n++;
        end
        tests_run++;
        if (fifo_fill !== 5'd0 || underrun !== 1'b0) begin
            tests_failed++; $display("FAIL drain_state: got fill %0d underrun %b expected 0/0", fifo_fill, underrun);
        end
        do_rd(seen);
        tests_run++;
        if (underrun !== 1'b1 || seen !== 32'h0 || fifo_fill !== 5'd0) begin
            tests_failed++; $display("FAIL underrun_set: got underrun %b bytes 0x%08h fill %0d expected 1/0/0", underrun, seen, fifo_fill);
        end
        repeat (5) tick();
        do_rd(seen);
        tests_run++;
        if (underrun !== 1'b1 || {bright_byte, blue_byte, green_byte, red_byte} !== 32'h0) begin
            tests_failed++; $display("FAIL underrun_hold: got underrun %b bytes 0x%08h expected 1/0",
                                     underrun, {bright_byte, blue_byte, green_byte, red_byte});
        end
        pulse_vsync();
        tests_run++;
        if (underrun !== 1'b0) begin tests_failed++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
        strobes = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (bus.addr_strobe) strobes++; end
        tests_run++;
        if (strobes != 0) begin tests_failed++; $display("FAIL disabled_strobe: got %0d expected 0", strobes); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen;
        logic [31:0] exp_w;
        int          n;
        base_addr = 30'h4000;
        enable = 1'b1;
        bus_delay = 0;
        pulse_vsync();
        n = 0;
        while (fifo_fill !== 5'd16 && n < 200) begin tick(); n++; end
        exp_w = model_pop();
        do_rd(seen);
        tests_run++;
        if (seen !== word_of(30'h4000)) begin tests_failed++; $display("FAIL b2b_first: got 0x%08h expected 0x%08h", seen, word_of(30'h4000)); end
        // A push can only land when fill was below full, so the near-full case is 15.
        n = 0;
        while (!bus.data_ready && n < 20) begin tick(); n++; end
        tests_run++;
        if (fifo_fill !== 5'd15 || !bus.data_ready) begin
            tests_failed++; $display("FAIL b2b_hi_pre: got fill %0d ready %b expected 15/1", fifo_fill, bus.data_ready);
        end
        exp_w = model_pop();
        do_rd(seen);
        bus_delay = 40;
        tests_run++;
        if (seen !== exp_w || fifo_fill !== 5'd15 || underrun !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_hi: got head 0x%08h fill %0d underrun %b expected 0x%08h/15/0", seen, fifo_fill, underrun, exp_w);
        end
        tests_run++;
        if ({bright_byte, blue_byte, green_byte, red_byte} !== word_of(30'h4002)) begin
            tests_failed++; $display("FAIL b2b_hi_head: got 0x%08h expected 0x%08h",
                                     {bright_byte, blue_byte, green_byte, red_byte}, word_of(30'h4002));
        end
        for (int i = 0; i < 14; i++) begin
            exp_w = model_pop();
            do_rd(seen);
            tests_run++;
            if (seen !== exp_w) begin tests_failed++; $display("FAIL b2b_drain%0d: got 0x%08h expected 0x%08h", i, seen, exp_w); end
            tick();
        end
        n = 0;
        while (!bus.data_ready && n < 60) begin tick(); n++; end
        tests_run++;
        if (fifo_fill !== 5'd1 || !bus.data_ready) begin
            tests_failed++; $display("FAIL b2b_lo_pre: got fill %0d ready %b expected 1/1", fifo_fill, bus.data_ready);
        end
        exp_w = model_pop();
        do_rd(seen);
        tests_run++;
        if (seen !== exp_w || fifo_fill !== 5'd1 || underrun !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_lo: got head 0x%08h fill %0d underrun %b expected 0x%08h/1/0", seen, fifo_fill, underrun, exp_w);
        end
        tests_run++;
        if ({bright_byte, blue_byte, green_byte, red_byte} !== word_of(30'h4011)) begin
            tests_failed++; $display("FAIL b2b_lo_head: got 0x%08h expected 0x%08h",
                                     {bright_byte, blue_byte, green_byte, red_byte}, word_of(30'h4011));
        end
    endtask

    task automatic test_reset_mid_cycle();
        int n;
        n = 0;
        while (!bus.addr_strobe && n < 20) begin tick(); n++; end
        tests_run++;
        if (!bus.addr_strobe) begin tests_failed++; $display("FAIL midrst_setup: got strobe 0 expected 1"); end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.addr_strobe !== 1'b0 || fifo_fill !== 5'd0) begin
            tests_failed++; $display("FAIL midrst_async: got strobe %b fill %0d expected 0/0", bus.addr_strobe, fifo_fill);
        end
        bus.data_ready = 1'b0;
        busy = 1'b0;
        pend = 1'b0;
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_steady_rd();
        test_frame_done();
        test_discard();
        test_underrun();
        test_back_to_back();
        test_reset_mid_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
